// File: rtl/branch_unit_pkg.sv
// branch_unit_pkg: shared definitions for the decode-stage branch unit.
//   br_type_e : branch kind encodings presented by decode (NONE/BEQ/BNE/JMP).
//   state_e   : branch unit FSM state encodings.
//   br_taken  : taken decision from branch kind and comparator equality.
package branch_unit_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_OPS = 2'b01,
    ST_REDIRECT = 2'b10,
    ST_FLUSH    = 2'b11
  } state_e;

  // JMP ignores the comparator; NONE is never taken.
  function automatic logic br_taken(input logic [1:0] kind, input logic eq);
    logic t;
    t = 1'b0;
    case (kind)
      BR_BEQ:  t = eq;
      BR_BNE:  t = ~eq;
      BR_JMP:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_unit.sv
// branch_unit: resolves decode-stage branches/jumps and steers fetch.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   br_valid, br_type     : decode presents a branch of the given kind
//   cmp_eq, ops_ready     : comparator result and operand-valid flag
//   br_target             : branch/jump target address
//   pc_src, next_pc       : registered fetch redirect select and address
//   flush_ifid            : registered IF/ID squash (FLUSH_CYCLES cycles per redirect)
//   stall                 : combinational PC/IF-ID freeze while operands are pending
//   br_done, misalign     : registered one-cycle resolution / misaligned-target pulses
//   taken_cnt             : wrapping count of redirects issued
//   dbg_state             : current FSM state (state_e encoding)
// Handshake: a branch is accepted when br_valid is high in IDLE; if operands are
// not ready the unit asserts stall and decode must hold br_type/br_target/cmp_eq
// stable until ops_ready rises. br_valid is ignored during REDIRECT/FLUSH.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic              cmp_eq,
  input  logic              ops_ready,
  input  logic [ADDR_W-1:0] br_target,
  output logic              pc_src,
  output logic [ADDR_W-1:0] next_pc,
  output logic              flush_ifid,
  output logic              stall,
  output logic              br_done,
  output logic              misalign,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [1:0]        dbg_state
);

  // Cycles spent in FLUSH after the single REDIRECT cycle.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pc_src_q, pc_src_d;
  logic              flush_q, flush_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              stall_c;
  logic              eval;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    npc_d    = npc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    stall_c  = 1'b0;
    eval     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          if (ops_ready || br_type == BR_JMP) begin
            eval = 1'b1;
          end else begin
            state_d = ST_WAIT_OPS;
            stall_c = 1'b1;
          end
        end
      end
      ST_WAIT_OPS: begin
        if (ops_ready) eval = 1'b1;
        else           stall_c = 1'b1;
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q <= 3'd1) begin
          state_d = ST_IDLE;
          fcnt_d  = 3'd0;
        end else begin
          fcnt_d  = fcnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Branch resolution: operands are sampled in the evaluating cycle.
    if (eval) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
      if (br_taken(br_type, cmp_eq)) begin
        if (br_target[1:0] == 2'b00) begin
          npc_d   = br_target;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_REDIRECT;
        end else begin
          mis_d   = 1'b1;
        end
      end
    end

    // Outputs are flopped from the next state so they line up with state_q.
    pc_src_d = (state_d == ST_REDIRECT);
    flush_d  = (state_d == ST_REDIRECT) || (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fcnt_q   <= 3'd0;
      npc_q    <= '0;
      cnt_q    <= '0;
      pc_src_q <= 1'b0;
      flush_q  <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      npc_q    <= npc_d;
      cnt_q    <= cnt_d;
      pc_src_q <= pc_src_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
    end
  end

  assign pc_src     = pc_src_q;
  assign next_pc    = npc_q;
  assign flush_ifid = flush_q;
  assign br_done    = done_q;
  assign misalign   = mis_q;
  assign taken_cnt  = cnt_q;
  // Gated by rst_n so every 1-bit output reads 0 while reset is held.
  assign stall      = stall_c & rst_n;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed bench for branch_unit. Two instances share the
// stimulus: u_a with default parameters, u_b with FLUSH_CYCLES=3, CNT_W=2.
// A timeline model per instance predicts every output each cycle; literal
// checks pin the model on the hand-computed scenarios.
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic [1:0]  br_type;
  logic        cmp_eq;
  logic        ops_ready;
  logic [31:0] br_target;

  logic        a_pc_src, a_flush, a_stall, a_done, a_mis;
  logic [31:0] a_npc;
  logic [15:0] a_cnt;
  logic [1:0]  a_state;
  logic        b_pc_src, b_flush, b_stall, b_done, b_mis;
  logic [31:0] b_npc;
  logic [1:0]  b_cnt;
  logic [1:0]  b_state;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_unit u_a (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
    .cmp_eq(cmp_eq), .ops_ready(ops_ready), .br_target(br_target),
    .pc_src(a_pc_src), .next_pc(a_npc), .flush_ifid(a_flush), .stall(a_stall),
    .br_done(a_done), .misalign(a_mis), .taken_cnt(a_cnt), .dbg_state(a_state)
  );

  branch_unit #(.ADDR_W(32), .FLUSH_CYCLES(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
    .cmp_eq(cmp_eq), .ops_ready(ops_ready), .br_target(br_target),
    .pc_src(b_pc_src), .next_pc(b_npc), .flush_ifid(b_flush), .stall(b_stall),
    .br_done(b_done), .misalign(b_mis), .taken_cnt(b_cnt), .dbg_state(b_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_fl: flush cycles still showing (including the current one); while
  // nonzero the unit is redirecting/flushing and ignores decode.
  int          m_F   [2] = '{1, 3};
  int unsigned m_mod [2] = '{65536, 4};
  int          m_fl  [2];
  bit          m_wait[2];
  logic [31:0] m_pc  [2];
  int unsigned m_cnt [2];
  bit          e_pcs [2], e_fls[2], e_done[2], e_mis[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fl[i] = 0; m_wait[i] = 0; m_pc[i] = '0; m_cnt[i] = 0;
      e_pcs[i] = 0; e_fls[i] = 0; e_done[i] = 0; e_mis[i] = 0;
    end
  endfunction

  function automatic void model_step(input int i);
    bit ev, tk;
    e_pcs[i] = 0; e_done[i] = 0; e_mis[i] = 0; e_fls[i] = 0;
    if (m_fl[i] > 0) begin
      m_fl[i]--;
      e_fls[i] = (m_fl[i] > 0);
    end else begin
      ev = m_wait[i] ? ops_ready : (br_valid && (ops_ready || br_type == 2'b11));
      if (!m_wait[i] && br_valid && !ev) m_wait[i] = 1;
      if (ev) begin
        m_wait[i] = 0;
        e_done[i] = 1;
        tk = (br_type == 2'b01 && cmp_eq) || (br_type == 2'b10 && !cmp_eq) || (br_type == 2'b11);
        if (tk && br_target[1:0] == 2'b00) begin
          m_pc[i]  = br_target;
          m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
          m_fl[i]  = m_F[i];
          e_pcs[i] = 1;
          e_fls[i] = 1;
        end else if (tk) begin
          e_mis[i] = 1;
        end
      end
    end
  endfunction

  function automatic bit model_stall(input int i);
    return rst_n && m_fl[i] == 0 && !ops_ready &&
           (m_wait[i] || (br_valid && br_type != 2'b11));
  endfunction

  // ---------------- compare process (scoreboard) ----------------
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) begin
        model_step(0);
        model_step(1);
      end
      #1;
      if (!rst_n) model_reset();
      chk("a_pc_src", a_pc_src, e_pcs[0]);
      chk("a_flush",  a_flush,  e_fls[0]);
      chk("a_done",   a_done,   e_done[0]);
      chk("a_mis",    a_mis,    e_mis[0]);
      chk("a_npc",    a_npc,    m_pc[0]);
      chk("a_cnt",    a_cnt,    m_cnt[0]);
      chk("b_pc_src", b_pc_src, e_pcs[1]);
      chk("b_flush",  b_flush,  e_fls[1]);
      chk("b_done",   b_done,   e_done[1]);
      chk("b_mis",    b_mis,    e_mis[1]);
      chk("b_npc",    b_npc,    m_pc[1]);
      chk("b_cnt",    b_cnt,    m_cnt[1]);
      #7;
      if (!rst_n) model_reset();
      chk("a_stall", a_stall, model_stall(0));
      chk("b_stall", b_stall, model_stall(1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [1:0] t, input logic eq,
                     input logic rdy, input logic [31:0] tgt);
    @(negedge clk);
    br_valid = v; br_type = t; cmp_eq = eq; ops_ready = rdy; br_target = tgt;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic at_post();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; br_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct { logic [1:0] t; logic eq; logic [31:0] tgt; } vec_t;
  vec_t vecs[6] = '{
    '{2'b00, 1'b1, 32'h0000_0080},   // NONE: resolves, never taken
    '{2'b01, 1'b0, 32'h0000_0080},   // BEQ not taken
    '{2'b10, 1'b0, 32'h0000_0084},   // BNE taken
    '{2'b01, 1'b1, 32'h0000_0091},   // BEQ taken, misaligned
    '{2'b11, 1'b0, 32'h0000_00a0},   // JMP, cmp_eq ignored
    '{2'b10, 1'b1, 32'h0000_0088}    // BNE not taken
  };

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_type = 2'b00; cmp_eq = 1'b0;
    ops_ready = 1'b1; br_target = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc_src", a_pc_src, 1'b0);
    chk("rst_npc",    a_npc,    32'h0);
    chk("rst_cnt",    a_cnt,    16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // BEQ taken, aligned
    cyc(1'b1, 2'b01, 1'b1, 1'b1, 32'h0000_0040);
    at_post();
    chk("beq_pc_src", a_pc_src, 1'b1);
    chk("beq_flush",  a_flush,  1'b1);
    chk("beq_npc",    a_npc,    32'h40);
    chk("beq_done",   a_done,   1'b1);
    chk("beq_cnt",    a_cnt,    16'd1);
    idle(4);

    // BNE with equal operands: not taken
    cyc(1'b1, 2'b10, 1'b1, 1'b1, 32'h0000_0060);
    at_post();
    chk("bne_done",   a_done,   1'b1);
    chk("bne_pc_src", a_pc_src, 1'b0);
    chk("bne_flush",  a_flush,  1'b0);
    chk("bne_cnt",    a_cnt,    16'd1);
    idle(2);

    // BEQ with operands late by 3 cycles
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0100);
      #3 chk("wait_stall", a_stall, 1'b1);
    end
    cyc(1'b1, 2'b01, 1'b1, 1'b1, 32'h0000_0100);
    #3 chk("wait_stall_drop", a_stall, 1'b0);
    at_post();
    chk("wait_pc_src", a_pc_src, 1'b1);
    chk("wait_npc",    a_npc,    32'h100);
    idle(4);

    // JMP to misaligned target
    cyc(1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0102);
    at_post();
    chk("mis_mis",    a_mis,    1'b1);
    chk("mis_done",   a_done,   1'b1);
    chk("mis_pc_src", a_pc_src, 1'b0);
    chk("mis_cnt",    a_cnt,    16'd2);
    chk("mis_npc",    a_npc,    32'h100);
    idle(2);

    // FLUSH_CYCLES=3 instance: JMP 0x200, br_valid held during flush
    cyc(1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0200);
    at_post();
    chk("f3_c1_flush",  b_flush,  1'b1);
    chk("f3_c1_pc_src", b_pc_src, 1'b1);
    cyc(1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0300);
    at_post();
    chk("f3_c2_flush",  b_flush,  1'b1);
    chk("f3_c2_pc_src", b_pc_src, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0300);
    at_post();
    chk("f3_c3_flush",  b_flush,  1'b1);
    chk("f3_c3_pc_src", b_pc_src, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 32'h0);
    at_post();
    chk("f3_end_flush", b_flush,  1'b0);
    chk("f3_npc",       b_npc,    32'h200);
    chk("f3_cnt",       b_cnt,    2'd3);
    idle(4);

    // Mixed vectors checked by the model
    foreach (vecs[j]) begin
      cyc(1'b1, vecs[j].t, vecs[j].eq, 1'b1, vecs[j].tgt);
      idle(4);
    end

    // CNT_W=2 wrap: five taken jumps from reset
    do_reset();
    idle(1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0010 + 32'(k) * 32'h10);
      at_post();
      case (k)
        0: chk("wrap_1", b_cnt, 2'd1);
        1: chk("wrap_2", b_cnt, 2'd2);
        2: chk("wrap_3", b_cnt, 2'd3);
        3: chk("wrap_0", b_cnt, 2'd0);
        default: chk("wrap_1b", b_cnt, 2'd1);
      endcase
      idle(3);
    end

    // Reset pulsed during REDIRECT
    cyc(1'b1, 2'b11, 1'b0, 1'b1, 32'h0000_0400);
    at_post();
    chk("rr_pre_pc_src", b_pc_src, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rr_a_pc_src", a_pc_src, 1'b0);
    chk("rr_a_flush",  a_flush,  1'b0);
    chk("rr_a_done",   a_done,   1'b0);
    chk("rr_a_npc",    a_npc,    32'h0);
    chk("rr_b_flush",  b_flush,  1'b0);
    chk("rr_b_cnt",    b_cnt,    2'd0);
    chk("rr_b_state",  b_state,  2'b00);
    @(negedge clk);
    br_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    at_post();
    chk("rr_post_pc_src", b_pc_src, 1'b0);
    chk("rr_post_flush",  b_flush,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
